// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: word RAM at low addresses plus a peripheral page
// holding a prescaled compare/interrupt timer and an LED register.
module dmem_mmio_responder #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int          DEPTH     = 2**ADDR_W;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) << 2;

  localparam logic [5:0] OFF_CNT  = 6'h0;
  localparam logic [5:0] OFF_CMP  = 6'h1;
  localparam logic [5:0] OFF_CTRL = 6'h2;
  localparam logic [5:0] OFF_STAT = 6'h3;
  localparam logic [5:0] OFF_LED  = 6'h4;

  typedef struct packed {
    logic [7:0] prescale;
    logic       irq_en;
    logic       autoclr;
    logic       en;
  } ctrl_t;

  logic [31:0] ram [DEPTH];
  logic [31:0] cnt, cmp;
  ctrl_t       ctrl;
  logic        match;
  logic [7:0]  led_r;
  logic [7:0]  pre_cnt;

  logic              is_mmio, is_ram;
  logic [5:0]        offs;
  logic [ADDR_W-1:0] ram_idx;
  logic              wr_cnt, wr_cmp, wr_ctrl, wr_stat, wr_led;
  logic              tick, match_set;

  assign is_mmio = (memaddr[31:8] == MMIO_BASE[31:8]);
  assign is_ram  = !is_mmio && ({1'b0, memaddr} < RAM_BYTES);
  assign offs    = memaddr[7:2];
  assign ram_idx = memaddr[ADDR_W+1:2];

  assign wr_cnt  = memwrite && is_mmio && (offs == OFF_CNT);
  assign wr_cmp  = memwrite && is_mmio && (offs == OFF_CMP);
  assign wr_ctrl = memwrite && is_mmio && (offs == OFF_CTRL);
  assign wr_stat = memwrite && is_mmio && (offs == OFF_STAT);
  assign wr_led  = memwrite && is_mmio && (offs == OFF_LED);

  assign tick      = ctrl.en && (pre_cnt == ctrl.prescale);
  assign match_set = tick && (cnt == cmp);

  assign led = led_r;
  assign irq = match && ctrl.irq_en;

  // RAM has no reset so its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram) ram[ram_idx] <= memwritedata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      cmp     <= 32'hFFFFFFFF;
      ctrl    <= '0;
      match   <= 1'b0;
      led_r   <= '0;
      pre_cnt <= '0;
    end else begin
      if (wr_cnt || wr_ctrl)   pre_cnt <= '0;
      else if (tick)           pre_cnt <= '0;
      else if (ctrl.en)        pre_cnt <= pre_cnt + 8'd1;

      // CPU store to CNT wins over a same-cycle tick.
      if (wr_cnt)              cnt <= memwritedata;
      else if (match_set)      cnt <= ctrl.autoclr ? '0 : cnt + 32'd1;
      else if (tick)           cnt <= cnt + 32'd1;

      // Match set wins over a same-cycle W1C.
      if (match_set)                      match <= 1'b1;
      else if (wr_stat && memwritedata[0]) match <= 1'b0;

      if (wr_cmp)  cmp   <= memwritedata;
      if (wr_ctrl) ctrl  <= '{prescale: memwritedata[15:8], irq_en: memwritedata[2],
                              autoclr: memwritedata[1], en: memwritedata[0]};
      if (wr_led)  led_r <= memwritedata[7:0];
    end
  end

  always_comb begin
    memreaddata = '0;
    if (is_mmio) begin
      case (offs)
        OFF_CNT:  memreaddata = cnt;
        OFF_CMP:  memreaddata = cmp;
        OFF_CTRL: memreaddata = {16'h0, ctrl.prescale, 5'h0, ctrl.irq_en, ctrl.autoclr, ctrl.en};
        OFF_STAT: memreaddata = {31'h0, match};
        OFF_LED:  memreaddata = {24'h0, led_r};
        default:  memreaddata = '0;
      endcase
    end else if (is_ram) begin
      memreaddata = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, timer, collisions, wrap, decode, async reset.
module tb_dmem_mmio_responder;

  localparam logic [31:0] CNT  = 32'hFFFF0000;
  localparam logic [31:0] CMP  = 32'hFFFF0004;
  localparam logic [31:0] CTRL = 32'hFFFF0008;
  localparam logic [31:0] STAT = 32'hFFFF000C;
  localparam logic [31:0] LED  = 32'hFFFF0010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwrite;
  logic [31:0] memaddr, memwritedata, memreaddata;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int errors = 0;

  dmem_mmio_responder dut (
    .clk(clk), .reset_n(reset_n), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata), .led(led), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Store lands on the next posedge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite = 1'b1; memaddr = a; memwritedata = d;
    @(posedge clk); #1;
    memwrite = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memaddr = a; #1;
    chk(tag, memreaddata, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; memwrite = 1'b0; memaddr = '0; memwritedata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cycles(1);

    // reset values
    rd("rst_cnt", CNT, 32'h0);
    rd("rst_cmp", CMP, 32'hFFFFFFFF);
    rd("rst_ctrl", CTRL, 32'h0);
    rd("rst_stat", STAT, 32'h0);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);

    // RAM store / load, byte offset ignored, read-before-write
    wr(32'h10, 32'h12345678);
    rd("ram_rd", 32'h10, 32'h12345678);
    rd("ram_rd_13", 32'h13, 32'h12345678);
    @(negedge clk);
    memwrite = 1'b1; memaddr = 32'h10; memwritedata = 32'hDEADBEEF; #1;
    chk("ram_same_cyc_old", memreaddata, 32'h12345678);
    @(posedge clk); #1;
    memwrite = 1'b0;
    rd("ram_new", 32'h10, 32'hDEADBEEF);

    // timer with autoclr and irq
    wr(CMP, 32'd5);
    wr(CTRL, 32'h7);
    cycles(5);
    rd("tmr_cnt5", CNT, 32'd5);
    chk("tmr_irq_pre", {31'h0, irq}, 32'h0);
    cycles(1);
    rd("tmr_cnt_clr", CNT, 32'd0);
    rd("tmr_stat", STAT, 32'h1);
    chk("tmr_irq", {31'h0, irq}, 32'h1);
    wr(STAT, 32'h1);
    chk("tmr_irq_w1c", {31'h0, irq}, 32'h0);
    rd("tmr_stat_w1c", STAT, 32'h0);
    wr(CTRL, 32'h0);

    // prescale 3: one increment per 4 cycles
    wr(CNT, 32'h0);
    wr(CMP, 32'hFFFFFFFF);
    wr(CTRL, 32'h0301);
    cycles(3);
    rd("pre_cnt3", CNT, 32'd0);
    cycles(1);
    rd("pre_cnt4", CNT, 32'd1);
    cycles(36);
    rd("pre_cnt40", CNT, 32'd10);

    // CNT write beats tick
    wr(CTRL, 32'h1);
    wr(CNT, 32'd100);
    rd("col_cnt_wr", CNT, 32'd100);
    cycles(1);
    rd("col_cnt_next", CNT, 32'd101);

    // W1C on match cycle: match stays
    wr(CTRL, 32'h0);
    wr(CNT, 32'd50);
    wr(CMP, 32'd52);
    wr(STAT, 32'h1);
    wr(CTRL, 32'h1);
    cycles(2);
    rd("col_pre_match", STAT, 32'h0);
    wr(STAT, 32'h1);
    rd("col_stat_kept", STAT, 32'h1);
    rd("col_cnt53", CNT, 32'd53);
    wr(CTRL, 32'h0);

    // wrap without autoclr
    wr(CNT, 32'hFFFFFFFF);
    wr(CMP, 32'h0);
    wr(STAT, 32'h1);
    wr(CTRL, 32'h1);
    cycles(1);
    rd("wrap_cnt0", CNT, 32'h0);
    rd("wrap_stat0", STAT, 32'h0);
    cycles(1);
    rd("wrap_stat1", STAT, 32'h1);
    rd("wrap_cnt1", CNT, 32'h1);
    wr(CTRL, 32'h0);
    rd("freeze_cnt", CNT, 32'h2);

    // decode: unmapped and out-of-range
    rd("unmap_rd", 32'h80000000, 32'h0);
    wr(32'h0, 32'h0);
    wr(32'h400, 32'hCAFE0000);
    rd("oor_rd", 32'h400, 32'h0);
    rd("oor_noalias", 32'h0, 32'h0);
    rd("mmio_hole", 32'hFFFF0020, 32'h0);
    wr(CTRL, 32'hFFFFFFF8);
    rd("ctrl_mask", CTRL, 32'h0000FF00);
    wr(CTRL, 32'h0);
    wr(LED, 32'h1A5);
    chk("led_out", {24'h0, led}, 32'hA5);
    rd("led_rd", LED, 32'hA5);

    // async reset mid-operation
    wr(CNT, 32'h0);
    wr(CMP, 32'h0);
    wr(CTRL, 32'h7);
    cycles(1);
    chk("ar_irq_pre", {31'h0, irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_irq", {31'h0, irq}, 32'h0);
    chk("ar_led", {24'h0, led}, 32'h0);
    memaddr = CTRL; #0.5;
    chk("ar_ctrl", memreaddata, 32'h0);
    memaddr = CMP; #0.5;
    chk("ar_cmp", memreaddata, 32'hFFFFFFFF);
    @(negedge clk);
    reset_n = 1'b1;
    rd("ar_cnt", CNT, 32'h0);
    rd("ar_stat", STAT, 32'h0);
    rd("ar_ram_kept", 32'h10, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
